playfield_controller: RTL

Owns the Tetris playfield state and produces the `objectMatrix`, `flash` and `score` buses consumed by the VGA UI display. It accepts landed-piece masks from the piece/movement logic through a valid/ready handshake, merges them into the field, and detects full rows. Full rows are flashed for a fixed time, then collapsed one row per cycle while the score advances. The block also raises a sticky game-over flag when a piece lands on occupied cells.

---
 rtl/tetris_pkg.sv | 20 ++
 rtl/row_collapse.sv | 29 ++
 rtl/playfield_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield types for the Tetris datapath.
// Used by the playfield controller and the VGA UI display.
package tetris_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 12;
  localparam int SCORE_W = 7;
  localparam int SCORE_MAX_DEFAULT = 99;

  typedef logic [ROWS-1:0][COLS-1:0] field_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_FLASH,
    S_COLLAPSE,
    S_GAMEOVER
  } pf_state_t;

endpackage

// File: rtl/row_collapse.sv
// Full-row detector and single-row remover for the playfield.
// Drops the lowest full row and shifts everything above it down.
module row_collapse
  import tetris_pkg::*;
(
  input  field_t           field,
  output logic             any_full,
  output logic [ROWS-1:0]  full,
  output field_t           collapsed
);

  logic [4:0] sel;

  always_comb begin
    sel = '0;
    full = '0;
    for (int r = 0; r < ROWS; r++) begin
      full[r] = &field[r];
      if (full[r]) sel = 5'(r);
    end
    any_full = |full;
    collapsed = field;
    for (int r = 1; r < ROWS; r++) begin
      if (5'(r) <= sel) collapsed[r] = field[r-1];
    end
    if (any_full) collapsed[0] = '0;
  end

endmodule

// File: rtl/playfield_controller.sv
// Tetris playfield owner: merge, row detect, flash, collapse, score.
// Feeds objectMatrix/flash/score to the VGA UI display.
module playfield_controller
  import tetris_pkg::*;
#(
  parameter int FLASH_CYCLES = 25_000_000,
  parameter int SCORE_MAX = SCORE_MAX_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_game,
  input  logic                       lock_valid,
  input  logic [ROWS-1:0][COLS-1:0]  lock_mask,
  output logic                       lock_ready,
  output logic [ROWS-1:0][COLS-1:0]  objectMatrix,
  output logic [ROWS-1:0][COLS-1:0]  flash,
  output logic [SCORE_W-1:0]         score,
  output logic                       busy,
  output logic                       game_over
);

  localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLASH_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SMAX = SCORE_W'(SCORE_MAX);

  pf_state_t       state;
  logic [CW-1:0]   cnt;
  logic            any_full;
  logic [ROWS-1:0] full;
  field_t          collapsed;
  field_t          full_cells;

  row_collapse u_collapse (
    .field     (objectMatrix),
    .any_full  (any_full),
    .full      (full),
    .collapsed (collapsed)
  );

  always_comb begin
    full_cells = '0;
    for (int r = 0; r < ROWS; r++) begin
      full_cells[r] = {COLS{full[r]}};
    end
  end

  assign lock_ready = (state == S_IDLE);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset || new_game) begin
      state <= S_IDLE;
      objectMatrix <= '0;
      flash <= '0;
      score <= '0;
      game_over <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lock_valid) begin
            objectMatrix <= objectMatrix | lock_mask;
            if (|(objectMatrix & lock_mask)) begin
              game_over <= 1'b1;
              state <= S_GAMEOVER;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          if (any_full) begin
            flash <= full_cells;
            cnt <= CNT_LOAD;
            state <= S_FLASH;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FLASH: begin
          if (cnt == '0) begin
            flash <= '0;
            state <= S_COLLAPSE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_COLLAPSE: begin
          // one row per cycle; the next full row is re-found after the shift
          if (any_full) begin
            objectMatrix <= collapsed;
            if (score < SMAX) score <= score + 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GAMEOVER: state <= S_GAMEOVER;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
